// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit signed/unsigned restoring divider for the EX stage.
// Produces {remainder, quotient} for HI/LO and a combinational stall request
// that holds the pipeline until the result is ready.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t              state, state_nxt;
    logic [5:0]          cnt, cnt_nxt;
    logic                ready_nxt;
    logic [63:0]         result_nxt;
    logic                load_ops;
    logic                step;

    // Latched operands and iteration registers (data only, no reset needed)
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   quo_q;
    logic [DATA_W-1:0]   dvsr_q;
    logic                sgn_q;
    logic                neg1_q;
    logic                neg2_q;

    logic signed [DATA_W-1:0] op1_s;
    logic signed [DATA_W-1:0] op2_s;
    logic [DATA_W:0]     trial;
    logic                fits;
    logic [DATA_W-1:0]   rem_step;
    logic [DATA_W-1:0]   quo_step;

    // Magnitude of an operand; negation wraps, so 0x80000000 maps to 2^31
    function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v,
                                              input logic en);
        if (en && (v < 0))
            return DATA_W'(-v);
        else
            return DATA_W'(v);
    endfunction

    // Conditional two's-complement negation used for the final sign fix-up
    function automatic logic [DATA_W-1:0] fix_sign(input logic [DATA_W-1:0] v,
                                                   input logic neg);
        logic signed [DATA_W-1:0] vs;
        vs = v;
        if (neg)
            return DATA_W'(-vs);
        else
            return v;
    endfunction

    assign op1_s = opdata1_i;
    assign op2_s = opdata2_i;

    // Stall the pipeline while a requested division has not yet produced its result
    assign stallreq_o = start_i & ~ready_o & ~annul_i;

    // One restoring step: shift {rem, quo} left and try to subtract the divisor
    always_comb begin
        trial    = {rem_q, quo_q[DATA_W-1]};
        fits     = (trial >= {1'b0, dvsr_q});
        rem_step = fits ? DATA_W'(trial - {1'b0, dvsr_q}) : trial[DATA_W-1:0];
        quo_step = {quo_q[DATA_W-2:0], fits};
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ready_o  <= ready_nxt;
            result_o <= result_nxt;
        end
    end

    // Next-state and output decode; annul wins over iteration in ON
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        ready_nxt  = ready_o;
        result_nxt = result_o;
        load_ops   = 1'b0;
        step       = 1'b0;
        case (state)
            FREE: begin
                ready_nxt  = 1'b0;
                result_nxt = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_nxt = BYZERO;
                    end else begin
                        state_nxt = ON;
                        cnt_nxt   = '0;
                        load_ops  = 1'b1;
                    end
                end
            end
            BYZERO: begin
                result_nxt = '0;
                if (annul_i) begin
                    state_nxt = FREE;
                    ready_nxt = 1'b0;
                end else begin
                    state_nxt = END;
                    ready_nxt = 1'b1;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_nxt  = FREE;
                    ready_nxt  = 1'b0;
                    result_nxt = '0;
                end else if (cnt != 6'd32) begin
                    step    = 1'b1;
                    cnt_nxt = cnt + 6'd1;
                end else begin
                    state_nxt  = END;
                    ready_nxt  = 1'b1;
                    result_nxt = {fix_sign(rem_q, sgn_q & neg1_q),
                                  fix_sign(quo_q, sgn_q & (neg1_q ^ neg2_q))};
                end
            end
            END: begin
                if (!start_i || annul_i) begin
                    state_nxt  = FREE;
                    ready_nxt  = 1'b0;
                    result_nxt = '0;
                end
            end
            default: begin
                state_nxt  = FREE;
                ready_nxt  = 1'b0;
                result_nxt = '0;
            end
        endcase
    end

    // Operand capture at accept, then one quotient bit per cycle
    always_ff @(posedge clk) begin
        if (load_ops) begin
            rem_q  <= '0;
            quo_q  <= mag(op1_s, signed_div_i);
            dvsr_q <= mag(op2_s, signed_div_i);
            sgn_q  <= signed_div_i;
            neg1_q <= opdata1_i[DATA_W-1];
            neg2_q <= opdata2_i[DATA_W-1];
        end else if (step) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with directed and random divisions.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   done     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: plain integer division; truncation toward zero, remainder follows dividend
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint signed sa, sbv, q, r;
        logic [31:0] qq, rr;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
        end else begin
            sa  = longint'({32'd0, a});
            sbv = longint'({32'd0, b});
        end
        q  = sa / sbv;
        r  = sa % sbv;
        qq = q[31:0];
        rr = r[31:0];
        return {rr, qq};
    endfunction

    // Monitor: pop the scoreboard whenever ready_o rises; also check the stall equation
    initial begin
        logic ready_prev;
        exp_t e;
        ready_prev = 1'b0;
        while (!done) begin
            @(negedge clk);
            #2;
            if (ready_o && !ready_prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready actual=1 expected=0 at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("result", result_o, e.res);
                    chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                end
            end
            ready_prev = ready_o;
            chk("stallreq", {63'd0, stallreq_o}, {63'd0, start_i & ~ready_o & ~annul_i});
        end
    end

    // Issue one division, hold start_i for extra cycles after ready, then release
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input int hold, input bit perturb);
        logic [63:0] e;
        int stall_n;
        bit got;
        e = ref_div(sgn, a, b);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        sb.push_back('{res: e, acc: cyc + 1, lat: (b == 32'd0) ? 1 : 33});
        stall_n = 0;
        got     = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            #1;
            if (ready_o) got = 1;
            else if (stallreq_o) stall_n++;
            if (!got) begin
                if (perturb && i == 5) begin
                    opdata1_i    = $urandom;
                    opdata2_i    = $urandom;
                    signed_div_i = ~signed_div_i;
                end
                @(negedge clk);
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 expected=1 a=%h b=%h", a, b);
        end
        chk("stall_cycles", 64'(stall_n), (b == 32'd0) ? 64'd2 : 64'd34);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            chk("hold_result", {ready_o, result_o[62:0]}, {1'b1, e[62:0]});
        end
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        #1;
        chk("release", {63'd0, ready_o}, 64'd0);
        chk("release_result", result_o, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_result", result_o, 64'd0);
        chk("reset_stall", {63'd0, stallreq_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_div(1'b0, 32'd100, 32'd7, 2, 1'b0);
        run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 0, 1'b0);
        run_div(1'b1, 32'h00000007, 32'hFFFFFFFE, 1, 1'b0);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
        run_div(1'b0, 32'hFFFFFFFF, 32'h00000001, 0, 1'b0);
        run_div(1'b0, 32'h12345678, 32'h00000000, 1, 1'b0);
        run_div(1'b1, 32'h87654321, 32'h00000000, 0, 1'b0);

        // Annul at cnt=10
        signed_div_i = 1'b0;
        opdata1_i    = 32'h12345678;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (11) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        #1;
        chk("annul_ready", {63'd0, ready_o}, 64'd0);
        chk("annul_result", result_o, 64'd0);
        chk("annul_stall", {63'd0, stallreq_o}, 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;
        @(negedge clk);
        run_div(1'b0, 32'd9, 32'd3, 0, 1'b0);

        // Reset at cnt=20
        signed_div_i = 1'b1;
        opdata1_i    = 32'hDEADBEEF;
        opdata2_i    = 32'd17;
        start_i      = 1'b1;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mid_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_mid_result", result_o, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        @(negedge clk);

        // Operands disturbed mid-division must not matter
        run_div(1'b1, 32'hFFFF0000, 32'd123, 0, 1'b1);
        run_div(1'b0, 32'hCAFEBABE, 32'h00010001, 0, 1'b1);

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = $urandom_range(1, 20);
                2:       rb = 32'd0 - 32'($urandom_range(1, 20));
                default: rb = (n % 6 == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            endcase
            run_div(1'($urandom_range(0, 1)), ra, rb, $urandom_range(0, 2),
                    (rb != 32'd0) && ($urandom_range(0, 1) == 1));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        done = 1;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
